// File: rtl/hms_time_counter.sv
// BCD hours:minutes:seconds timekeeper driven by a 1 Hz data strobe, with a
// RUN / SET_HR / SET_MIN mode FSM for setting the time from two button pulses.

module hms_bcd_pair #(
  parameter logic [3:0] MAX_T = 4'd5,
  parameter logic [3:0] MAX_O = 4'd9
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       at_max
);
  assign at_max = (tens == MAX_T) && (ones == MAX_O);

  always_ff @(posedge clk_in) begin
    if (reset || clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens <= 4'd0;
        ones <= 4'd0;
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= 4'd0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end
endmodule

module hms_time_counter #(
  parameter int HOUR_MODULUS = 24
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic       sec_pulse,
  output logic       rollover
);
  if (HOUR_MODULUS != 12 && HOUR_MODULUS != 24) begin : g_bad_modulus
    $error("hms_time_counter: HOUR_MODULUS must be 12 or 24");
  end

  localparam logic [3:0] HR_MAX_T = 4'((HOUR_MODULUS - 1) / 10);
  localparam logic [3:0] HR_MAX_O = 4'((HOUR_MODULUS - 1) % 10);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_t;

  mode_t state;
  logic  tick_d;
  logic  tick_rise, count, set_inc;

  // Field index: 0 = seconds, 1 = minutes, 2 = hours.
  logic [2:0]      inc, clr, at_max;
  logic [2:0][3:0] tens, ones;

  assign tick_rise = tick_in & ~tick_d;
  assign count     = (state == RUN) & tick_rise;
  // A mode press in the same cycle swallows the increment.
  assign set_inc   = btn_inc & ~btn_mode;

  assign inc[0] = count;
  assign inc[1] = (count & at_max[0]) | ((state == SET_MIN) & set_inc);
  assign inc[2] = (count & at_max[0] & at_max[1]) | ((state == SET_HR) & set_inc);
  assign clr    = {2'b00, (state == SET_MIN) & btn_mode};

  for (genvar g = 0; g < 3; g++) begin : g_field
    localparam logic [3:0] MT = (g == 2) ? HR_MAX_T : 4'd5;
    localparam logic [3:0] MO = (g == 2) ? HR_MAX_O : 4'd9;
    hms_bcd_pair #(.MAX_T(MT), .MAX_O(MO)) u_pair (
      .clk_in (clk_in),
      .reset  (reset),
      .inc    (inc[g]),
      .clr    (clr[g]),
      .tens   (tens[g]),
      .ones   (ones[g]),
      .at_max (at_max[g])
    );
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= RUN;
      tick_d    <= 1'b0;
      sec_pulse <= 1'b0;
      rollover  <= 1'b0;
    end else begin
      tick_d    <= tick_in;
      sec_pulse <= count;
      rollover  <= count & (&at_max);
      if (btn_mode) begin
        case (state)
          RUN:     state <= SET_HR;
          SET_HR:  state <= SET_MIN;
          default: state <= RUN;
        endcase
      end
    end
  end

  assign mode     = state;
  assign sec_tens = tens[0];
  assign sec_ones = ones[0];
  assign min_tens = tens[1];
  assign min_ones = ones[1];
  assign hr_tens  = tens[2];
  assign hr_ones  = ones[2];
endmodule

// File: tb/tb_hms_time_counter.sv
// Directed bench for hms_time_counter: a 24-hour and a 12-hour instance share
// stimulus; expected values are hand-computed constants.

module tb_hms_time_counter;
  logic clk_in = 1'b0;
  logic reset = 1'b0, tick_in = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;

  logic [3:0] a_ht, a_ho, a_mt, a_mo, a_st, a_so;
  logic [3:0] b_ht, b_ho, b_mt, b_mo, b_st, b_so;
  logic [1:0] a_mode, b_mode;
  logic       a_pulse, b_pulse, a_roll, b_roll;
  logic [23:0] hms24, hms12;

  int n_cmp = 0;
  int n_err = 0;

  always #4 clk_in = ~clk_in;

  hms_time_counter #(.HOUR_MODULUS(24)) dut24 (
    .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_tens(a_ht), .hr_ones(a_ho), .min_tens(a_mt), .min_ones(a_mo),
    .sec_tens(a_st), .sec_ones(a_so), .mode(a_mode), .sec_pulse(a_pulse), .rollover(a_roll));

  hms_time_counter #(.HOUR_MODULUS(12)) dut12 (
    .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hr_tens(b_ht), .hr_ones(b_ho), .min_tens(b_mt), .min_ones(b_mo),
    .sec_tens(b_st), .sec_ones(b_so), .mode(b_mode), .sec_pulse(b_pulse), .rollover(b_roll));

  assign hms24 = {a_ht, a_ho, a_mt, a_mo, a_st, a_so};
  assign hms12 = {b_ht, b_ho, b_mt, b_mo, b_st, b_so};

  typedef struct {
    logic        tick, bmode, binc;
    logic [1:0]  emode;
    logic [23:0] ehms;
    logic        epulse, eroll;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic t, input logic bm, input logic bi);
    tick_in  = t;
    btn_mode = bm;
    btn_inc  = bi;
    @(posedge clk_in);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  vec_t tbl[13];
  int   stray;

  initial begin
    // Simultaneous-event and edge-detect sequence starting from 00:00:00 RUN.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 24'h000001, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 24'h000001, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h000001, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'd1, 24'h000002, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 24'h010002, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'd1, 24'h010002, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'd2, 24'h010002, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd2, 24'h010102, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'd0, 24'h010100, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 24'h010100, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd0, 24'h010100, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 24'h010101, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 24'h010101, 1'b0, 1'b0};

    @(posedge clk_in); #1;

    // Reset state
    do_reset();
    check("reset hms24", 32'(hms24), 32'h0);
    check("reset hms12", 32'(hms12), 32'h0);
    check("reset mode", 32'(a_mode), 32'd0);
    check("reset pulses", 32'({a_pulse, a_roll, b_pulse, b_roll}), 32'd0);

    // First tick: one cycle latency, then held high for 1000 cycles
    cycle(1'b1, 1'b0, 1'b0);
    check("tick1 hms24", 32'(hms24), 32'h000001);
    check("tick1 pulse", 32'(a_pulse), 32'd1);
    stray = 0;
    for (int k = 0; k < 1000; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (a_pulse || hms24 != 24'h000001) stray++;
    end
    check("hold high stray", 32'(stray), 32'd0);
    check("hold high hms24", 32'(hms24), 32'h000001);

    // Set hours with wrap, minutes with wrap, back to RUN
    cycle(1'b0, 1'b1, 1'b0);
    incs(25);
    check("set_hr mode", 32'(a_mode), 32'd1);
    check("set_hr hms24", 32'(hms24), 32'h010001);
    check("set_hr hms12", 32'(hms12), 32'h010001);
    cycle(1'b0, 1'b1, 1'b0);
    incs(61);
    check("set_min mode", 32'(a_mode), 32'd2);
    check("set_min hms24", 32'(hms24), 32'h010101);
    cycle(1'b0, 1'b1, 1'b0);
    check("leave set mode", 32'(a_mode), 32'd0);
    check("leave set hms24", 32'(hms24), 32'h010100);

    // Ticks ignored in SET_HR; mode+inc together drops the increment
    cycle(1'b0, 1'b1, 1'b0);
    stray = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (a_pulse) stray++;
      cycle(1'b0, 1'b0, 1'b0);
      if (a_pulse) stray++;
    end
    check("set_hr tick pulses", 32'(stray), 32'd0);
    check("set_hr tick hms24", 32'(hms24), 32'h010100);
    cycle(1'b0, 1'b1, 1'b1);
    check("mode+inc mode", 32'(a_mode), 32'd2);
    check("mode+inc hms24", 32'(hms24), 32'h010100);

    // Table-driven simultaneous-event sequence
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].tick, tbl[i].bmode, tbl[i].binc);
      check($sformatf("tbl[%0d] hms24", i), 32'(hms24), 32'(tbl[i].ehms));
      check($sformatf("tbl[%0d] hms12", i), 32'(hms12), 32'(tbl[i].ehms));
      check($sformatf("tbl[%0d] mode", i), 32'(a_mode), 32'(tbl[i].emode));
      check($sformatf("tbl[%0d] pulse", i), 32'(a_pulse), 32'(tbl[i].epulse));
      check($sformatf("tbl[%0d] roll", i), 32'(a_roll), 32'(tbl[i].eroll));
    end

    // Full rollover: 23:59:58 (24h) and 11:59:58 (12h)
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    incs(23);
    cycle(1'b0, 1'b1, 1'b0);
    incs(59);
    cycle(1'b0, 1'b1, 1'b0);
    ticks(58);
    check("pre-roll hms24", 32'(hms24), 32'h235958);
    check("pre-roll hms12", 32'(hms12), 32'h115958);
    cycle(1'b1, 1'b0, 1'b0);
    check("59 hms24", 32'(hms24), 32'h235959);
    check("59 roll", 32'(a_roll), 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("wrap hms24", 32'(hms24), 32'h000000);
    check("wrap hms12", 32'(hms12), 32'h000000);
    check("wrap pulses 24", 32'({a_pulse, a_roll}), 32'd3);
    check("wrap pulses 12", 32'({b_pulse, b_roll}), 32'd3);
    cycle(1'b0, 1'b0, 1'b0);
    check("post-wrap pulses", 32'({a_pulse, a_roll, b_pulse, b_roll}), 32'd0);

    // Reset at 12:34:56 while in SET_MIN
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    incs(12);
    cycle(1'b0, 1'b1, 1'b0);
    incs(34);
    cycle(1'b0, 1'b1, 1'b0);
    ticks(56);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("pre-reset mode", 32'(a_mode), 32'd2);
    check("pre-reset hms24", 32'(hms24), 32'h123456);
    check("pre-reset hms12", 32'(hms12), 32'h003456);
    do_reset();
    check("mid reset hms24", 32'(hms24), 32'h0);
    check("mid reset mode", 32'(a_mode), 32'd0);
    check("mid reset pulses", 32'({a_pulse, a_roll}), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    check("after reset tick", 32'(hms24), 32'h000001);
    check("after reset pulse", 32'(a_pulse), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hms_time_counter.md
Name: hms_time_counter

Overview:
- Timekeeping stage fed by the 1 Hz divider output; counts seconds, minutes and hours in BCD for the display driver.
- The 1 Hz square wave is treated as data: it is rising-edge-detected in the clk_in domain and never used as a clock.
- A three-state mode FSM lets the user set hours and minutes with two pre-debounced single-cycle button pulses.

Parameters:
- HOUR_MODULUS, 24, hour count range 0..HOUR_MODULUS-1; legal values are 12 and 24 only.

Ports:
- clk_in  input  1  system clock, 125 MHz
- reset  input  1  synchronous, active-high reset
- tick_in  input  1  1 Hz square wave, synchronous to clk_in; each rising edge is one second
- btn_mode  input  1  single-cycle pulse, advances the mode FSM
- btn_inc  input  1  single-cycle pulse, increments the field selected in a set mode
- hr_tens  output  4  BCD hours tens digit
- hr_ones  output  4  BCD hours ones digit
- min_tens  output  4  BCD minutes tens digit
- min_ones  output  4  BCD minutes ones digit
- sec_tens  output  4  BCD seconds tens digit
- sec_ones  output  4  BCD seconds ones digit
- mode  output  2  00 = RUN, 01 = SET_HR, 10 = SET_MIN; 11 is never driven
- sec_pulse  output  1  one-cycle pulse when seconds advance
- rollover  output  1  one-cycle pulse on wrap from max time to 00:00:00

Behaviour:
- Reset: clock clk_in; reset is synchronous and active-high. On reset all digits = 0, mode = RUN, sec_pulse = 0, rollover = 0, and the edge-detect register tick_d = 0. Reset mid-operation aborts any set mode on the next edge. All outputs are registered.
- Edge detect: tick_rise = tick_in & ~tick_d; tick_d <= tick_in every cycle in all modes. Latency: the digits update on the clk_in edge that samples tick_rise, i.e. one cycle after tick_in goes high. sec_pulse is high for that same single cycle.
- RUN counting on tick_rise:
  - sec_ones 9 -> 0 carries to sec_tens.
  - sec_tens 5 with sec_ones 9 -> 00, carries to minutes.
  - Minutes use the same 59 -> 00 rule and carry to hours.
  - Hours wrap HOUR_MODULUS-1 -> 0, e.g. 23 -> 00 when HOUR_MODULUS = 24, or 11 -> 00 when 12.
  - Full wrap 23:59:59 -> 00:00:00 asserts rollover for one cycle, coincident with sec_pulse.
- Digit invariants: every digit stays a legal BCD value at all times; tens digits never exceed 5 for min/sec or 2 for hours.
- FSM transitions on btn_mode: RUN -> SET_HR -> SET_MIN -> RUN.
  - Leaving SET_MIN clears sec_tens and sec_ones to 0.
  - Minutes and hours are kept.
- Set modes:
  - tick_rise is ignored: no count, no sec_pulse, and it is not queued. tick_d still tracks tick_in.
  - btn_inc in SET_HR: hours += 1, wrapping HOUR_MODULUS-1 -> 0 with no carry.
  - btn_inc in SET_MIN: minutes += 1, wrapping 59 -> 00 with no carry into hours.
  - Each increment takes effect on the edge that samples btn_inc.
- btn_inc in RUN is ignored.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: the mode change wins and btn_inc is dropped.
  - tick_rise and btn_mode in the same cycle while in RUN: the count is applied and the mode moves to SET_HR on the same edge.
  - tick_rise and btn_mode in the same cycle while in SET_MIN: the count is dropped, seconds clear to 00 and mode returns to RUN.
- tick_in held high for many cycles produces exactly one tick_rise.
- Implementation target: 150-250 lines of RTL.

Test Plan:
- Reset, then tick_in low to high -> exactly one cycle later sec_ones = 1 and sec_pulse = 1 for one cycle; 00:00:01 is held while tick_in stays high for 1000 cycles.
- Preload 23:59:58 via set mode, return to RUN, apply 2 tick rises -> 23:59:59, then 00:00:00 with rollover = 1 for one cycle; repeat with HOUR_MODULUS = 12 from 11:59:59 -> 00:00:00.
- btn_mode once, then 25 btn_inc pulses -> mode = 01 and hours read 01 (wrapped past 23).
- btn_mode again, then 61 btn_inc pulses -> minutes = 01, hours unchanged.
- btn_mode again -> mode = 00 and seconds = 00.
- In SET_HR, apply 3 tick rises -> no digit changes and no sec_pulse; assert btn_mode and btn_inc together -> mode = 10 and hours unchanged.
- Assert reset at 12:34:56 in SET_MIN -> all digits 0, mode = 00 and both pulses 0 on the next cycle; the next tick rise gives 00:00:01.
